// File: rtl/spi_agent_pkg.sv
// -----------------------------------------------------------------------------
// spi_agent_pkg
// Shared definitions for the SPI master shift engine.
//   SPI_DATA_W : default bits per transfer
//   SPI_DIV_W  : default width of the SCK half-period divider
//   state_t    : FSM state encodings S_IDLE/S_SETUP/S_SHIFT/S_HOLD
// -----------------------------------------------------------------------------
package spi_agent_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_DIV_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_master_agent_if.sv
// -----------------------------------------------------------------------------
// spi_master_agent_if
// Byte handshake between the command controller and the SPI shift engine.
//   transfer_req   : level request, held by the controller until transfer_ready
//   to_agent       : byte to transmit, captured on the accept cycle
//   transfer_ready : 1-cycle pulse, request accepted
//   transfer_done  : 1-cycle pulse, from_agent valid
//   from_agent     : received byte, held until the next transfer_done
// Modports: master = controller side, slave = shift-engine side.
// -----------------------------------------------------------------------------
interface spi_master_agent_if
  import spi_agent_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);

  logic              transfer_req;
  logic              transfer_ready;
  logic [DATA_W-1:0] to_agent;
  logic              transfer_done;
  logic [DATA_W-1:0] from_agent;

  modport master (
    output transfer_req,
    output to_agent,
    input  transfer_ready,
    input  transfer_done,
    input  from_agent
  );

  modport slave (
    input  transfer_req,
    input  to_agent,
    output transfer_ready,
    output transfer_done,
    output from_agent
  );

endinterface

// File: rtl/spi_half_tick.sv
// -----------------------------------------------------------------------------
// spi_half_tick
// Half-period timer for SCK. The divider value is latched on load; the counter
// runs 0..div and tick is high in the cycle where count == div, so a half-period
// lasts div+1 clk cycles.
//   clk, rst : clock, asynchronous active-high reset
//   load     : latch div_in and zero the counter
//   clear    : zero the counter
//   div_in   : divider value to latch
//   tick     : end of the current half-period
// -----------------------------------------------------------------------------
module spi_half_tick
  import spi_agent_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [DIV_W-1:0] div_in,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  assign tick = (cnt_q == div_q);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q + DIV_W'(1);
    if (load) begin
      div_d = div_in;
      cnt_d = '0;
    end else if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values computed before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/spi_master_agent.sv
// -----------------------------------------------------------------------------
// spi_master_agent
// SPI master shift engine. Accepts one byte per request, shifts it out on MOSI
// while shifting MISO in, and returns the received byte with a done pulse.
// Chip select belongs to the controller; only SCK and MOSI are driven here.
//   clk, rst    : clock, asynchronous active-high reset
//   spi_clk_div : SCK half-period = spi_clk_div+1 clk cycles (latched on accept)
//   cpol, cpha  : SPI mode (latched on accept; cpol also sets idle SCK live)
//   bus         : controller handshake (spi_master_agent_if.slave)
//   sck, mosi   : registered SPI outputs
//   miso        : SPI data in
// Build option: define SPI_AGENT_LSB_FIRST_EN for LSB-first shifting;
// otherwise MSB first.
// -----------------------------------------------------------------------------
module spi_master_agent
  import spi_agent_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DIV_W  = SPI_DIV_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIV_W-1:0]    spi_clk_div,
  input  logic                cpol,
  input  logic                cpha,
  spi_master_agent_if.slave   bus,
  output logic                sck,
  output logic                mosi,
  input  logic                miso
);

  localparam int                EDGE_W    = $clog2(2*DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_W-1);

`ifdef SPI_AGENT_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   from_q, from_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;

  logic                accept;
  logic                tick;
  logic                first_bit, cur_bit, next_bit;
  logic [DATA_W-1:0]   tx_shifted, rx_shifted;
  logic                lead_edge, sample_now, drive_now;

  assign accept = (state_q == S_IDLE) && bus.transfer_req;

  // The counter is held at zero while idle so the setup half-period starts
  // counting from the accept edge.
  spi_half_tick #(.DIV_W(DIV_W)) u_half_tick (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .clear  (state_q == S_IDLE),
    .div_in (spi_clk_div),
    .tick   (tick)
  );

  // Bit-order selection: the shift direction is fixed at build time.
  assign first_bit  = LSB_FIRST ? bus.to_agent[0] : bus.to_agent[DATA_W-1];
  assign cur_bit    = LSB_FIRST ? tx_q[0]         : tx_q[DATA_W-1];
  assign next_bit   = LSB_FIRST ? tx_q[1]         : tx_q[DATA_W-2];
  assign tx_shifted = LSB_FIRST ? (tx_q >> 1)     : (tx_q << 1);
  assign rx_shifted = LSB_FIRST ? {miso, rx_q[DATA_W-1:1]}
                                : {rx_q[DATA_W-2:0], miso};

  // Even edge index = leading edge. cpha=1 re-drives the first bit at e=0, so
  // cur_bit is driven and the register shifts on every leading edge; cpha=0
  // drives the following bit on trailing edges, skipping the final one.
  assign lead_edge  = ~edge_q[0];
  assign sample_now = cpha_q ? ~lead_edge : lead_edge;
  assign drive_now  = cpha_q ? lead_edge  : (~lead_edge && (edge_q != LAST_EDGE));

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    from_d  = from_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        sck_d = cpol;
        if (accept) begin
          tx_d    = bus.to_agent;
          rx_d    = '0;
          cpol_d  = cpol;
          cpha_d  = cpha;
          mosi_d  = first_bit;
          edge_d  = '0;
          ready_d = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (tick) begin
          sck_d  = ~sck_q;
          edge_d = edge_q + EDGE_W'(1);
          if (sample_now) rx_d = rx_shifted;
          if (drive_now) begin
            mosi_d = cpha_q ? cur_bit : next_bit;
            tx_d   = tx_shifted;
          end
          if (edge_q == LAST_EDGE) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tick) begin
          from_d  = rx_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      from_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      from_q  <= from_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign sck                = sck_q;
  assign mosi               = mosi_q;
  assign bus.transfer_ready = ready_q;
  assign bus.transfer_done  = done_q;
  assign bus.from_agent     = from_q;

endmodule

// File: tb/tb_spi_master_agent.sv
// -----------------------------------------------------------------------------
// tb_spi_master_agent
// Directed bench for spi_master_agent: SPI modes 0..3, divider timing,
// mid-transfer configuration changes, back-to-back requests and reset
// mid-transfer. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_spi_master_agent;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] spi_clk_div;
  logic       cpol, cpha;
  logic       sck, mosi, miso;

  spi_master_agent_if #(.DATA_W(8)) bus ();

  spi_master_agent #(.DATA_W(8), .DIV_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_clk_div (spi_clk_div),
    .cpol        (cpol),
    .cpha        (cpha),
    .bus         (bus.slave),
    .sck         (sck),
    .mosi        (mosi),
    .miso        (miso)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Per-transfer observations.
  int         r_ready_cyc, r_done_cyc, r_rises, r_ready_cnt;
  int         r_lead_chg, r_trail_chg, r_other_chg;
  logic [7:0] r_rx, r_mosi_seq;
  logic       r_sck_at_ready, r_sck_at_done;
  bit         r_timeout;

`ifdef SPI_AGENT_LSB_FIRST_EN
  localparam logic [7:0] SEQ_12 = 8'h48;
`else
  localparam logic [7:0] SEQ_12 = 8'h12;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // mode: 0 = miso loops back mosi, 1 = miso tied high, 2 = slave returns slv
  // MSB first, driving each bit on the SCK leading edge.
  task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] div,
                      input logic pol, input logic pha, input int mode,
                      input logic [7:0] slv, input bit mid_change);
    logic sck_prev, mosi_prev;
    int   lead_idx;
    bit   got_ready;
    int   budget;
    cpol = pol; cpha = pha; spi_clk_div = div;
    bus.to_agent = tx; bus.transfer_req = 1'b1;
    r_ready_cyc = 0; r_done_cyc = 0; r_rises = 0; r_ready_cnt = 0;
    r_lead_chg = 0; r_trail_chg = 0; r_other_chg = 0;
    r_rx = '0; r_mosi_seq = '0; r_sck_at_ready = 1'b0; r_sck_at_done = 1'b0;
    r_timeout = 1'b1; got_ready = 1'b0; lead_idx = 0;
    sck_prev = sck; mosi_prev = mosi;
    budget = 20 * (int'(div) + 1) + 20;
    for (int i = 0; i < budget; i++) begin
      step();
      if (got_ready) begin
        if (sck != sck_prev) begin
          bit leading;
          leading = (sck_prev == pol);
          if (sck) r_rises++;
          if (mosi != mosi_prev) begin
            if (leading) r_lead_chg++;
            else         r_trail_chg++;
          end
          if (leading != pha) r_mosi_seq = {r_mosi_seq[6:0], mosi_prev};
          if (mode == 2 && leading && lead_idx < 8) begin
            miso = slv[7-lead_idx];
            lead_idx++;
          end
        end else if (mosi != mosi_prev) begin
          r_other_chg++;
        end
      end
      if (bus.transfer_ready) begin
        r_ready_cnt++;
        if (!got_ready) begin
          got_ready = 1'b1;
          r_ready_cyc = cyc;
          r_sck_at_ready = sck;
          if (mid_change) begin
            spi_clk_div = 8'h10; cpol = ~pol; bus.to_agent = ~tx;
          end
        end
      end
      if (mode == 0)      miso = mosi;
      else if (mode == 1) miso = 1'b1;
      sck_prev = sck; mosi_prev = mosi;
      if (bus.transfer_done) begin
        r_done_cyc = cyc; r_rx = bus.from_agent; r_sck_at_done = sck;
        bus.transfer_req = 1'b0; r_timeout = 1'b0;
        break;
      end
    end
    if (r_timeout) bus.transfer_req = 1'b0;
    check({tag, "_timeout"}, 32'(r_timeout), 32'd0);
  endtask

  initial begin
    int done1;
    int edges;
    int done_pulses;
    logic sck_prev;
    rst = 1'b1; bus.transfer_req = 1'b0; bus.to_agent = '0;
    cpol = 1'b0; cpha = 1'b0; spi_clk_div = '0; miso = 1'b0;
    step(); step();
    check("rst_ready", 32'(bus.transfer_ready), 32'd0);
    check("rst_done",  32'(bus.transfer_done),  32'd0);
    check("rst_from",  32'(bus.from_agent),     32'd0);
    check("rst_sck",   32'(sck),                32'd0);
    check("rst_mosi",  32'(mosi),               32'd0);
    rst = 1'b0;
    step();
    cpol = 1'b1; step();
    check("idle_sck_cpol1", 32'(sck), 32'd1);
    cpol = 1'b0; step();
    check("idle_sck_cpol0", 32'(sck), 32'd0);

    // Mode 0, div 0, loopback.
    xfer("m0", 8'hA5, 8'd0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    check("m0_latency",  32'(r_done_cyc - r_ready_cyc), 32'd18);
    check("m0_rx",       32'(r_rx),          32'hA5);
    check("m0_rises",    32'(r_rises),       32'd8);
    check("m0_mosi_seq", 32'(r_mosi_seq),    32'hA5);
    check("m0_ready_cnt",32'(r_ready_cnt),   32'd1);
    check("m0_sck_done", 32'(r_sck_at_done), 32'd0);
    step();

    // Asymmetric byte exposes bit order on MOSI.
    xfer("ord", 8'h12, 8'd2, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    check("ord_latency",  32'(r_done_cyc - r_ready_cyc), 32'd54);
    check("ord_rx",       32'(r_rx),       32'h12);
    check("ord_mosi_seq", 32'(r_mosi_seq), 32'(SEQ_12));
    step();

    // Mode 3, div 3, slave returns 0xC3.
    xfer("m3", 8'h3C, 8'd3, 1'b1, 1'b1, 2, 8'hC3, 1'b0);
    check("m3_latency",   32'(r_done_cyc - r_ready_cyc), 32'd72);
    check("m3_rx",        32'(r_rx),           32'hC3);
    check("m3_mosi_seq",  32'(r_mosi_seq),     32'h3C);
    check("m3_sck_ready", 32'(r_sck_at_ready), 32'd1);
    check("m3_sck_done",  32'(r_sck_at_done),  32'd1);
    check("m3_rises",     32'(r_rises),        32'd8);
    step();

    // Mode 1 / mode 2, div 1, miso tied high.
    xfer("m1", 8'h55, 8'd1, 1'b0, 1'b1, 1, 8'h00, 1'b0);
    check("m1_latency",   32'(r_done_cyc - r_ready_cyc), 32'd36);
    check("m1_rx",        32'(r_rx),        32'hFF);
    check("m1_lead_chg",  32'(r_lead_chg),  32'd7);
    check("m1_trail_chg", 32'(r_trail_chg), 32'd0);
    check("m1_other_chg", 32'(r_other_chg), 32'd0);
    step();
    xfer("m2", 8'h55, 8'd1, 1'b1, 1'b0, 1, 8'h00, 1'b0);
    check("m2_latency",   32'(r_done_cyc - r_ready_cyc), 32'd36);
    check("m2_rx",        32'(r_rx),        32'hFF);
    check("m2_lead_chg",  32'(r_lead_chg),  32'd0);
    check("m2_trail_chg", 32'(r_trail_chg), 32'd7);
    check("m2_other_chg", 32'(r_other_chg), 32'd0);
    step();

    // Divider, polarity and data changed right after accept.
    xfer("mid", 8'h5A, 8'd2, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    check("mid_latency",  32'(r_done_cyc - r_ready_cyc), 32'd54);
    check("mid_rx",       32'(r_rx),          32'h5A);
    check("mid_rises",    32'(r_rises),       32'd8);
    check("mid_sck_done", 32'(r_sck_at_done), 32'd0);
    step();
    check("mid_sck_after", 32'(sck), 32'd1);
    step();

    // Back-to-back requests.
    xfer("b2b1", 8'h01, 8'd0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    check("b2b1_rx", 32'(r_rx), 32'h01);
    done1 = r_done_cyc;
    xfer("b2b2", 8'h80, 8'd0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    check("b2b2_rx",    32'(r_rx),        32'h80);
    check("b2b2_ready", 32'(r_ready_cyc), 32'(done1 + 1));
    step();

    // Reset after the seventh SCK edge.
    cpol = 1'b0; cpha = 1'b0; spi_clk_div = 8'd0;
    bus.to_agent = 8'hFF; bus.transfer_req = 1'b1;
    edges = 0; sck_prev = sck;
    for (int i = 0; i < 100 && edges < 7; i++) begin
      step();
      if (bus.transfer_ready) bus.transfer_req = 1'b0;
      if (sck != sck_prev) edges++;
      sck_prev = sck;
      miso = mosi;
    end
    check("rst7_edges", 32'(edges), 32'd7);
    bus.transfer_req = 1'b0;
    rst = 1'b1;
    #1;
    check("rst7_sck",   32'(sck),                32'd0);
    check("rst7_mosi",  32'(mosi),               32'd0);
    check("rst7_ready", 32'(bus.transfer_ready), 32'd0);
    check("rst7_done",  32'(bus.transfer_done),  32'd0);
    check("rst7_from",  32'(bus.from_agent),     32'd0);
    step(); step();
    rst = 1'b0;
    done_pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.transfer_done) done_pulses++;
    end
    check("rst7_no_done", 32'(done_pulses), 32'd0);
    xfer("post", 8'h12, 8'd0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    check("post_latency", 32'(r_done_cyc - r_ready_cyc), 32'd18);
    check("post_rx",      32'(r_rx), 32'h12);

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
